wb_rram_bridge: RTL and testbench
=================================

Name: wb_rram_bridge

Overview:
- Wishbone slave bridge between the Caravel user-space bus and the RRAM in-memory-compute top level.
- Converts classic single-beat Wishbone cycles into the top level's bus signals: address, write data, write enable, start_operation pulse, FIFO pop pulses, and read data return.
- Owns a small local register set: control, status counters, pop windows. Generates wbs_ack_o with a deterministic, parameterised read latency.

Parameters:
- BASE_ADDR, 32'h3000_0000, slave base; decode on wbs_adr_i[31:12] == BASE_ADDR[31:12].
- RD_LAT, 2, cycles from downstream read/pop issue to valid wishbone_data_out; legal range 1..15.
- CFG_LO, 12'h400, first offset of the config pass-through window.
- CFG_HI, 12'h7FC, last offset of the config pass-through window.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous reset, active-high.
- wbs_cyc_i  in  1  bus cycle.
- wbs_stb_i  in  1  strobe.
- wbs_we_i  in  1  write enable from the master.
- wbs_sel_i  in  4  byte selects.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  single-cycle acknowledge.
- wbs_dat_o  out  32  read data, valid with ack.
- wishbone_address_bus  out  32  address to the top level.
- wishbone_data_in  out  32  write data to the top level.
- core_we  out  1  write enable to the top level.
- start_operation  out  1  one-cycle start pulse.
- rd_sync_fifo_output_buffer_ADC  out  1  one-cycle ADC FIFO pop.
- rd_sync_fifo_output_buffer_CSA  out  1  one-cycle CSA FIFO pop.
- wishbone_data_out  in  32  read data from the top level.

Behaviour:
- Reset: every output 0; FSM in IDLE; all counters 0. Reset asserted in any state returns to IDLE on the same edge, with no ack and no pulse.
- Hit: wbs_cyc_i & wbs_stb_i & address match. Non-hit requests are ignored: no ack, outputs unchanged.
- Offset map (wbs_adr_i[11:0]):
  - 0x000 CTRL: write with bit0 = 1 issues start_operation; read returns 0.
  - 0x004 STATUS: read-only = {start_cnt[15:0], adc_pop_cnt[7:0], csa_pop_cnt[7:0]}.
  - 0x008 ADC_POP: read only.
  - 0x00C CSA_POP: read only.
  - CFG_LO..CFG_HI: forwarded reads and writes.
  - Any other in-range offset: acked; reads return 0; writes dropped.
- Counters are free-running and wrap: 16'hFFFF -> 0, 8'hFF -> 0.
- FSM states: IDLE, ISSUE, WAIT, ACK.
  - IDLE -> ISSUE: on a hit. Latch address, data, we and decode on the accepting edge.
  - ISSUE (1 cycle):
    - Config write: drive wishbone_address_bus = latched address, wishbone_data_in, core_we = 1.
    - Config read: same address, core_we = 0.
    - CTRL write with bit0 = 1: start_operation = 1; start_cnt += 1.
    - ADC_POP read: ADC pop pulse = 1; adc_pop_cnt += 1. CSA_POP read: CSA pop pulse = 1; csa_pop_cnt += 1.
    - Next state: writes, local reads and unmapped accesses -> ACK; config reads and pops -> WAIT.
  - WAIT: hold wishbone_address_bus for exactly RD_LAT cycles; pulses and core_we are 0. On the final WAIT edge, capture wishbone_data_out into the wbs_dat_o register. Then -> ACK.
  - ACK (1 cycle): wbs_ack_o = 1 with wbs_dat_o valid; then -> IDLE.
  - In IDLE, wbs_ack_o = 0 and wbs_dat_o = 0.
  - A new request is never accepted in the cycle in which ack is high.
- Latency from the accepting edge to ack:
  - Writes and local reads: ack on cycle N+2.
  - Config reads and pops: ack on cycle N+2+RD_LAT.
- Outside ISSUE and WAIT, wishbone_address_bus, wishbone_data_in and core_we are 0.
- Partial writes (wbs_sel_i != 4'hF) to CTRL or the config window are acked without any side effect.
- Master drops wbs_cyc_i during ISSUE or WAIT:
  - FSM aborts to IDLE on the next edge with no ack.
  - A pulse already issued stands; its counter is not rolled back.

Decomposition:
- Shared package wb_rram_pkg holds:
  - The FSM state enum.
  - Offset constants: OFS_CTRL, OFS_STATUS, OFS_ADC_POP, OFS_CSA_POP.
  - Default CFG_LO/CFG_HI and the RD_LAT bounds.
- One natural sub-module, wb_rram_addr_decode: combinational offset classification into {ctrl, status, adc_pop, csa_pop, cfg, unmapped}.
- FSM, counters and the capture register stay in the top of the block.

Test Plan:
- Reset mid-WAIT of a config read -> no ack; all outputs 0 on the next cycle; STATUS reads 0 afterwards.
- Write 32'h1 to BASE+0x000 -> start_operation high for exactly 1 cycle at N+1; ack at N+2; STATUS[31:16] = 1.
- Write 32'hDEAD_BEEF to BASE+0x400, sel = F -> for one cycle: wishbone_address_bus = 32'h3000_0400, wishbone_data_in = 32'hDEADBEEF, core_we = 1; then ack.
- Read BASE+0x008 with RD_LAT = 2, downstream returning 32'h0000_0ABC -> ADC pop pulse once; ack at N+4 with wbs_dat_o = 32'h0000_0ABC; adc_pop_cnt = 1.
- 256 reads of CSA_POP -> csa_pop_cnt wraps to 0; exactly one pulse per read.
- Access at 32'h3000_1000, and a write with sel = 4'h3 to 0x400 -> no ack for the first; ack with core_we never asserted for the second.

Source files
------------

// File: rtl/wb_rram_pkg.sv
// Shared types and constants for the Wishbone-to-RRAM bridge.
package wb_rram_pkg;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ACK} state_e;

  typedef enum logic [2:0] {
    CLS_CTRL, CLS_STATUS, CLS_ADC_POP, CLS_CSA_POP, CLS_CFG, CLS_UNMAP
  } cls_e;

  localparam logic [11:0] OFS_CTRL    = 12'h000;
  localparam logic [11:0] OFS_STATUS  = 12'h004;
  localparam logic [11:0] OFS_ADC_POP = 12'h008;
  localparam logic [11:0] OFS_CSA_POP = 12'h00C;

  localparam logic [11:0] CFG_LO_DEF = 12'h400;
  localparam logic [11:0] CFG_HI_DEF = 12'h7FC;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 15;

  // Keeps the wait counter legal if a parent passes an out-of-range latency.
  function automatic int clamp_rd_lat(input int v);
    if (v < RD_LAT_MIN) return RD_LAT_MIN;
    if (v > RD_LAT_MAX) return RD_LAT_MAX;
    return v;
  endfunction

endpackage

// File: rtl/wb_rram_bridge_if.sv
// Wishbone slave side plus the RRAM top-level bus, bundled for the bridge.
interface wb_rram_bridge_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic [31:0] wishbone_address_bus;
  logic [31:0] wishbone_data_in;
  logic        core_we;
  logic        start_operation;
  logic        rd_sync_fifo_output_buffer_ADC;
  logic        rd_sync_fifo_output_buffer_CSA;
  logic [31:0] wishbone_data_out;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wishbone_data_out,
    output wbs_ack_o, wbs_dat_o, wishbone_address_bus, wishbone_data_in,
    output core_we, start_operation,
    output rd_sync_fifo_output_buffer_ADC, rd_sync_fifo_output_buffer_CSA
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wishbone_data_out,
    input  wbs_ack_o, wbs_dat_o, wishbone_address_bus, wishbone_data_in,
    input  core_we, start_operation,
    input  rd_sync_fifo_output_buffer_ADC, rd_sync_fifo_output_buffer_CSA
  );
endinterface

// File: rtl/wb_rram_addr_decode.sv
// Classifies the 12-bit in-page offset into the bridge's register map.
module wb_rram_addr_decode
  import wb_rram_pkg::*;
#(
  parameter logic [11:0] CFG_LO = CFG_LO_DEF,
  parameter logic [11:0] CFG_HI = CFG_HI_DEF
) (
  input  logic [11:0] i_ofs,
  output cls_e        o_cls
);
  always_comb begin
    o_cls = CLS_UNMAP;
    if      (i_ofs == OFS_CTRL)                  o_cls = CLS_CTRL;
    else if (i_ofs == OFS_STATUS)                o_cls = CLS_STATUS;
    else if (i_ofs == OFS_ADC_POP)               o_cls = CLS_ADC_POP;
    else if (i_ofs == OFS_CSA_POP)               o_cls = CLS_CSA_POP;
    else if (i_ofs >= CFG_LO && i_ofs <= CFG_HI) o_cls = CLS_CFG;
  end
endmodule

// File: rtl/wb_rram_bridge.sv
// Single-beat Wishbone slave that forwards config accesses to the RRAM top,
// issues start/pop pulses and returns data with a fixed read latency.
module wb_rram_bridge
  import wb_rram_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          RD_LAT    = 2,
  parameter logic [11:0] CFG_LO    = CFG_LO_DEF,
  parameter logic [11:0] CFG_HI    = CFG_HI_DEF
) (
  input logic             clk,
  input logic             rst,
  wb_rram_bridge_if.slave bus
);
  localparam int         RD_LAT_C  = clamp_rd_lat(RD_LAT);
  localparam logic [3:0] WAIT_INIT = 4'(RD_LAT_C - 1);

  state_e      r_state;
  logic        r_ack, r_core_we, r_start, r_pop_adc, r_pop_csa;
  logic [31:0] r_dat_o, r_addr_o, r_wdat_o;
  logic [15:0] r_start_cnt;
  logic [7:0]  r_adc_cnt, r_csa_cnt;
  logic        r_rd_fwd, r_rd_status;
  logic [3:0]  r_wcnt;

  cls_e        w_cls;
  logic        w_hit, w_wr, w_rd;

  wb_rram_addr_decode #(.CFG_LO(CFG_LO), .CFG_HI(CFG_HI)) u_dec (
    .i_ofs(bus.wbs_adr_i[11:0]),
    .o_cls(w_cls)
  );

  assign w_hit = bus.wbs_cyc_i & bus.wbs_stb_i &
                 (bus.wbs_adr_i[31:12] == BASE_ADDR[31:12]);
  // Partial writes are treated as no-ops, so only full-word writes count.
  assign w_wr  = bus.wbs_we_i & (bus.wbs_sel_i == 4'hF);
  assign w_rd  = ~bus.wbs_we_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ack       <= 1'b0;
      r_dat_o     <= '0;
      r_addr_o    <= '0;
      r_wdat_o    <= '0;
      r_core_we   <= 1'b0;
      r_start     <= 1'b0;
      r_pop_adc   <= 1'b0;
      r_pop_csa   <= 1'b0;
      r_start_cnt <= '0;
      r_adc_cnt   <= '0;
      r_csa_cnt   <= '0;
      r_rd_fwd    <= 1'b0;
      r_rd_status <= 1'b0;
      r_wcnt      <= '0;
    end else begin
      r_core_we <= 1'b0;
      r_start   <= 1'b0;
      r_pop_adc <= 1'b0;
      r_pop_csa <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_ack    <= 1'b0;
          r_dat_o  <= '0;
          r_addr_o <= '0;
          r_wdat_o <= '0;
          if (w_hit) begin
            r_state     <= S_ISSUE;
            r_rd_fwd    <= w_rd & (w_cls inside {CLS_CFG, CLS_ADC_POP, CLS_CSA_POP});
            r_rd_status <= w_rd & (w_cls == CLS_STATUS);
            // Outputs for the ISSUE cycle are set here so they are registered.
            if (w_cls == CLS_CFG && (w_rd || w_wr))
              r_addr_o <= bus.wbs_adr_i;
            if (w_cls inside {CLS_ADC_POP, CLS_CSA_POP} && w_rd)
              r_addr_o <= bus.wbs_adr_i;
            if (w_cls == CLS_CFG && w_wr) begin
              r_wdat_o  <= bus.wbs_dat_i;
              r_core_we <= 1'b1;
            end
            if (w_cls == CLS_CTRL && w_wr && bus.wbs_dat_i[0]) begin
              r_start     <= 1'b1;
              r_start_cnt <= r_start_cnt + 16'd1;
            end
            if (w_cls == CLS_ADC_POP && w_rd) begin
              r_pop_adc <= 1'b1;
              r_adc_cnt <= r_adc_cnt + 8'd1;
            end
            if (w_cls == CLS_CSA_POP && w_rd) begin
              r_pop_csa <= 1'b1;
              r_csa_cnt <= r_csa_cnt + 8'd1;
            end
          end
        end
        S_ISSUE: begin
          r_wdat_o <= '0;
          if (!bus.wbs_cyc_i) begin
            r_state  <= S_IDLE;
            r_addr_o <= '0;
          end else if (r_rd_fwd) begin
            r_state <= S_WAIT;
            r_wcnt  <= WAIT_INIT;
          end else begin
            r_state  <= S_ACK;
            r_ack    <= 1'b1;
            r_addr_o <= '0;
            r_dat_o  <= r_rd_status ? {r_start_cnt, r_adc_cnt, r_csa_cnt} : 32'h0;
          end
        end
        S_WAIT: begin
          if (!bus.wbs_cyc_i) begin
            r_state  <= S_IDLE;
            r_addr_o <= '0;
          end else if (r_wcnt == 4'd0) begin
            r_state  <= S_ACK;
            r_ack    <= 1'b1;
            r_dat_o  <= bus.wishbone_data_out;
            r_addr_o <= '0;
          end else begin
            r_wcnt <= r_wcnt - 4'd1;
          end
        end
        S_ACK: begin
          r_state <= S_IDLE;
          r_ack   <= 1'b0;
          r_dat_o <= '0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.wbs_ack_o                      = r_ack;
  assign bus.wbs_dat_o                      = r_dat_o;
  assign bus.wishbone_address_bus           = r_addr_o;
  assign bus.wishbone_data_in               = r_wdat_o;
  assign bus.core_we                        = r_core_we;
  assign bus.start_operation                = r_start;
  assign bus.rd_sync_fifo_output_buffer_ADC = r_pop_adc;
  assign bus.rd_sync_fifo_output_buffer_CSA = r_pop_csa;
endmodule

// File: tb/tb_wb_rram_bridge.sv
// Directed plus randomized checks of wb_rram_bridge against a transaction-level model.
module tb_wb_rram_bridge;
  localparam int          RD_LAT = 2;
  localparam logic [31:0] BASE   = 32'h3000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   m_start = 0, m_adc = 0, m_csa = 0;

  wb_rram_bridge_if bus();

  wb_rram_bridge #(.BASE_ADDR(BASE), .RD_LAT(RD_LAT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ack"},   32'(bus.wbs_ack_o), 32'h0);
    chk({tag, "_dat"},   bus.wbs_dat_o, 32'h0);
    chk({tag, "_addr"},  bus.wishbone_address_bus, 32'h0);
    chk({tag, "_wdat"},  bus.wishbone_data_in, 32'h0);
    chk({tag, "_ctl"},   32'({bus.core_we, bus.start_operation,
                              bus.rd_sync_fifo_output_buffer_ADC,
                              bus.rd_sync_fifo_output_buffer_CSA}), 32'h0);
  endtask

  function automatic logic [31:0] status_model();
    return {16'(m_start), 8'(m_adc), 8'(m_csa)};
  endfunction

  // Expected outcome of one accepted access, from the register map rules.
  function automatic void ref_model(input logic [11:0] ofs, input logic we, input logic [3:0] sel,
      input logic [31:0] wdat, input logic [31:0] dsv, output int e_lat, output logic [31:0] e_rd,
      output int e_st, output int e_adc, output int e_csa, output int e_we);
    bit full = (sel == 4'hF);
    bit cfg  = (ofs >= 12'h400) && (ofs <= 12'h7FC);
    e_lat = 2; e_rd = 32'h0; e_st = 0; e_adc = 0; e_csa = 0; e_we = 0;
    if (!we) begin
      if (cfg)                 begin e_lat = 2 + RD_LAT; e_rd = dsv; end
      else if (ofs == 12'h008) begin e_lat = 2 + RD_LAT; e_rd = dsv; e_adc = 1; end
      else if (ofs == 12'h00C) begin e_lat = 2 + RD_LAT; e_rd = dsv; e_csa = 1; end
      else if (ofs == 12'h004) e_rd = status_model();
    end else if (full) begin
      if (ofs == 12'h000 && wdat[0]) e_st = 1;
      if (cfg) e_we = 1;
    end
  endfunction

  task automatic xfer(input logic [31:0] adr, input logic we, input logic [3:0] sel,
      input logic [31:0] wdat, input logic [31:0] dsv, output bit acked, output int lat,
      output logic [31:0] rdat, output int n_st, output int n_adc, output int n_csa,
      output int n_we, output logic [31:0] we_adr, output logic [31:0] we_dat);
    @(negedge clk);
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = we;
    bus.wbs_sel_i = sel;  bus.wbs_adr_i = adr;  bus.wbs_dat_i = wdat;
    bus.wishbone_data_out = dsv;
    acked = 0; lat = 0; rdat = '0; n_st = 0; n_adc = 0; n_csa = 0; n_we = 0;
    we_adr = '0; we_dat = '0;
    for (int i = 1; i <= 40 && !acked; i++) begin
      @(negedge clk);
      n_st  += int'(bus.start_operation);
      n_adc += int'(bus.rd_sync_fifo_output_buffer_ADC);
      n_csa += int'(bus.rd_sync_fifo_output_buffer_CSA);
      if (bus.core_we) begin
        n_we++; we_adr = bus.wishbone_address_bus; we_dat = bus.wishbone_data_in;
      end
      if (bus.wbs_ack_o) begin acked = 1; lat = i; rdat = bus.wbs_dat_o; end
    end
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
    bus.wbs_sel_i = 4'h0; bus.wbs_adr_i = '0;   bus.wbs_dat_i = '0;
    @(negedge clk);
  endtask

  task automatic run(input string tag, input logic [11:0] ofs, input logic we,
      input logic [3:0] sel, input logic [31:0] wdat, input logic [31:0] dsv);
    bit acked; int lat, n_st, n_adc, n_csa, n_we;
    int e_lat, e_st, e_adc, e_csa, e_we;
    logic [31:0] rdat, we_adr, we_dat, e_rd;
    ref_model(ofs, we, sel, wdat, dsv, e_lat, e_rd, e_st, e_adc, e_csa, e_we);
    xfer({BASE[31:12], ofs}, we, sel, wdat, dsv, acked, lat, rdat, n_st, n_adc, n_csa, n_we,
         we_adr, we_dat);
    chk({tag, "_acked"}, 32'(acked), 32'h1);
    chk({tag, "_lat"},   32'(lat),   32'(e_lat));
    chk({tag, "_rdat"},  rdat,       e_rd);
    chk({tag, "_start"}, 32'(n_st),  32'(e_st));
    chk({tag, "_adc"},   32'(n_adc), 32'(e_adc));
    chk({tag, "_csa"},   32'(n_csa), 32'(e_csa));
    chk({tag, "_we"},    32'(n_we),  32'(e_we));
    if (e_we != 0) begin
      chk({tag, "_weadr"}, we_adr, {BASE[31:12], ofs});
      chk({tag, "_wedat"}, we_dat, wdat);
    end
    m_start += e_st; m_adc += e_adc; m_csa += e_csa;
  endtask

  initial begin
    bit acked; int lat, n_st, n_adc, n_csa, n_we;
    logic [31:0] rdat, we_adr, we_dat;
    logic [11:0] ofs;
    logic [3:0]  sel;
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
    bus.wbs_sel_i = 4'h0; bus.wbs_adr_i = '0;   bus.wbs_dat_i = '0;
    bus.wishbone_data_out = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk_idle("rst_hold");
    rst = 1'b0;
    @(negedge clk);
    chk_idle("rst_rel");
    run("status0", 12'h004, 1'b0, 4'hF, 32'h0, 32'hFFFF_FFFF);

    // Directed register map cases
    run("ctrl_go",  12'h000, 1'b1, 4'hF, 32'h0000_0001, 32'h0);
    run("status1",  12'h004, 1'b0, 4'hF, 32'h0, 32'h0);
    run("ctrl_rd",  12'h000, 1'b0, 4'hF, 32'h0, 32'h1234_5678);
    run("cfg_wr",   12'h400, 1'b1, 4'hF, 32'hDEAD_BEEF, 32'h0);
    run("cfg_rdhi", 12'h7FC, 1'b0, 4'hF, 32'h0, 32'h5A5A_A5A5);
    run("adc_pop",  12'h008, 1'b0, 4'hF, 32'h0, 32'h0000_0ABC);
    run("status2",  12'h004, 1'b0, 4'hF, 32'h0, 32'h0);
    run("unmap_lo", 12'h3FC, 1'b1, 4'hF, 32'hFFFF_FFFF, 32'h0);
    run("unmap_hi", 12'h800, 1'b0, 4'hF, 32'h0, 32'h1111_1111);
    run("part_wr",  12'h400, 1'b1, 4'h3, 32'hCAFE_F00D, 32'h0);
    run("part_ctl", 12'h000, 1'b1, 4'h7, 32'h0000_0001, 32'h0);

    // Out-of-page access must be ignored
    xfer(32'h3000_1000, 1'b1, 4'hF, 32'h0000_0001, 32'h0, acked, lat, rdat, n_st, n_adc,
         n_csa, n_we, we_adr, we_dat);
    chk("miss_ack",   32'(acked), 32'h0);
    chk("miss_pulse", 32'(n_st + n_adc + n_csa + n_we), 32'h0);

    // CSA counter wraps after 256 pops
    for (int i = 0; i < 256; i++) run("csa_wrap", 12'h00C, 1'b0, 4'hF, 32'h0, $urandom);
    run("status_wrap", 12'h004, 1'b0, 4'hF, 32'h0, 32'h0);

    // Randomized mix
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 5))
        0: ofs = 12'h000;
        1: ofs = 12'h004;
        2: ofs = 12'h008;
        3: ofs = 12'h00C;
        4: ofs = 12'(12'h400 + 4 * $urandom_range(0, 255));
        default: ofs = ($urandom_range(0, 1) == 0) ? 12'(12'h010 + 4 * $urandom_range(0, 251))
                                                   : 12'(12'h800 + 4 * $urandom_range(0, 511));
      endcase
      sel = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      run("rand", ofs, 1'($urandom), sel, $urandom, $urandom);
    end
    run("status_rand", 12'h004, 1'b0, 4'hF, 32'h0, 32'h0);

    // Master abandons an ADC pop during WAIT: pulse stands, no ack
    @(negedge clk);
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b0;
    bus.wbs_sel_i = 4'hF; bus.wbs_adr_i = BASE + 32'h8;
    @(negedge clk);
    chk("abort_pop", 32'(bus.rd_sync_fifo_output_buffer_ADC), 32'h1);
    @(negedge clk);
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
    m_adc++;
    acked = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.wbs_ack_o) acked = 1;
    end
    chk("abort_noack", 32'(acked), 32'h0);
    chk_idle("abort_idle");
    run("status_abort", 12'h004, 1'b0, 4'hF, 32'h0, 32'h0);

    // Reset in the middle of a config read's WAIT
    run("pre_rst_go", 12'h000, 1'b1, 4'hF, 32'h1, 32'h0);
    @(negedge clk);
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b0;
    bus.wbs_sel_i = 4'hF; bus.wbs_adr_i = BASE + 32'h404; bus.wishbone_data_out = 32'h7777_7777;
    @(negedge clk);
    @(negedge clk);
    chk("wait_addr", bus.wishbone_address_bus, BASE + 32'h404);
    rst = 1'b1;
    @(negedge clk);
    chk_idle("rst_wait");
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
    rst = 1'b0;
    m_start = 0; m_adc = 0; m_csa = 0;
    @(negedge clk);
    chk_idle("post_rst");
    run("status_rst", 12'h004, 1'b0, 4'hF, 32'h0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
